// File: rtl/render_pkg.sv
// Shared types for the renderer control path.
package render_pkg;

  localparam int unsigned ANGLE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RENDER,
    SWAP
  } seq_state_t;

  typedef logic [ANGLE_W-1:0] angle_t;

endpackage

// File: rtl/frame_sequencer_if.sv
// Handshake bundle between frame_sequencer and the frame clock / renderer /
// framebuffer side. master = sequencer, slave = its environment.
interface frame_sequencer_if #(
  parameter int unsigned ANGLE_W = 8,
  parameter int unsigned DROP_W  = 16
) ();

  logic               update;
  logic               done;
  logic               start;
  logic               busy;
  logic [ANGLE_W-1:0] yaw;
  logic [ANGLE_W-1:0] pitch;
  logic               buf_sel;
  logic [31:0]        frame_count;
  logic [DROP_W-1:0]  drop_count;

  modport master (
    input  update, done,
    output start, busy, yaw, pitch, buf_sel, frame_count, drop_count
  );

  modport slave (
    output update, done,
    input  start, busy, yaw, pitch, buf_sel, frame_count, drop_count
  );

endinterface

// File: rtl/tick_detect.sv
// Rising-edge detector: one-cycle pulse on each 0->1 transition of `in`.
module tick_detect (
  input  logic sysclk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic in_q;

  // Delay the input by one cycle for edge comparison.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) in_q <= 1'b0;
    else        in_q <= in;
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame control loop: tick -> launch render -> wait done -> swap buffers
// and advance angles. Ticks arriving while a frame is in flight are dropped.
// Build option: define FRAME_STATS_EN to implement frame_count/drop_count;
// otherwise both outputs are tied to zero.
module frame_sequencer #(
  parameter int unsigned ANGLE_W    = render_pkg::ANGLE_W,
  parameter int unsigned YAW_STEP   = 2,
  parameter int unsigned PITCH_STEP = 1,
  parameter int unsigned DROP_W     = 16
) (
  input logic               sysclk,
  input logic               rst_n,
  frame_sequencer_if.master bus
);

  import render_pkg::*;

  seq_state_t         state_q, state_d;
  logic               tick;
  logic [ANGLE_W-1:0] yaw_q, pitch_q;
  logic               buf_sel_q;

  tick_detect u_tick_detect (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .in     (bus.update),
    .pulse  (tick)
  );

  // State register.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. A tick seen in SWAP is the pending tick: it sends us
  // straight back to LAUNCH and is consumed on the same edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tick) state_d = LAUNCH;
      LAUNCH:  state_d = RENDER;
      RENDER:  if (bus.done) state_d = SWAP;
      SWAP:    state_d = tick ? LAUNCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state register only.
  always_comb begin
    bus.start = (state_q == LAUNCH);
    bus.busy  = (state_q != IDLE);
  end

  // Angles and buffer select move only on the SWAP edge, so they are stable
  // for the whole start..done window.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      yaw_q     <= '0;
      pitch_q   <= '0;
      buf_sel_q <= 1'b0;
    end else if (state_q == SWAP) begin
      yaw_q     <= yaw_q + ANGLE_W'(YAW_STEP);
      pitch_q   <= pitch_q + ANGLE_W'(PITCH_STEP);
      buf_sel_q <= ~buf_sel_q;
    end
  end

  assign bus.yaw     = yaw_q;
  assign bus.pitch   = pitch_q;
  assign bus.buf_sel = buf_sel_q;

`ifdef FRAME_STATS_EN
  logic [31:0]       frame_count_q;
  logic [DROP_W-1:0] drop_count_q;
  logic              drop;

  assign drop = tick && ((state_q == LAUNCH) || (state_q == RENDER));

  // Completed-frame counter (wraps) and saturating dropped-tick counter.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      if (state_q == SWAP) frame_count_q <= frame_count_q + 32'd1;
      if (drop && !(&drop_count_q)) drop_count_q <= drop_count_q + DROP_W'(1);
    end
  end

  assign bus.frame_count = frame_count_q;
  assign bus.drop_count  = drop_count_q;
`else
  assign bus.frame_count = '0;
  assign bus.drop_count  = '0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer. Expected counter values follow the
// FRAME_STATS_EN build option (zero when the counters are compiled out).
module tb_frame_sequencer;

`ifdef FRAME_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int start_cnt   = 0;
  int s0          = 0;

  frame_sequencer_if #(.ANGLE_W(8), .DROP_W(16)) bus ();

  frame_sequencer #(
    .ANGLE_W    (8),
    .YAW_STEP   (2),
    .PITCH_STEP (1),
    .DROP_W     (16)
  ) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  // Count start pulses: start is held for the cycle ending at this edge.
  always @(posedge sysclk) begin
    if (bus.start === 1'b1) start_cnt++;
  end

  function automatic int cnt(input int n);
    return Stats ? n : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int busy, input int buf_sel,
                           input int yaw, input int pitch, input int fc, input int dc);
    chk({tag, ".busy"},        32'(bus.busy),        32'(busy));
    chk({tag, ".buf_sel"},     32'(bus.buf_sel),     32'(buf_sel));
    chk({tag, ".yaw"},         32'(bus.yaw),         32'(yaw));
    chk({tag, ".pitch"},       32'(bus.pitch),       32'(pitch));
    chk({tag, ".frame_count"}, bus.frame_count,      32'(fc));
    chk({tag, ".drop_count"},  32'(bus.drop_count),  32'(dc));
  endtask

  initial begin
    bus.update = 1'b0;
    bus.done   = 1'b0;

    // Reset state.
    repeat (3) @(negedge sysclk);
    chk("reset.start", 32'(bus.start), 32'd0);
    chk_state("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge sysclk);

    // T1: single tick, done 10 cycles after start.
    s0 = start_cnt;
    bus.update = 1'b1;
    @(negedge sysclk);
    chk("t1.start_latency", 32'(bus.start), 32'd1);
    chk("t1.yaw_at_start", 32'(bus.yaw), 32'd0);
    bus.update = 1'b0;
    repeat (10) @(negedge sysclk);
    bus.done = 1'b1;
    @(negedge sysclk);
    bus.done = 1'b0;
    repeat (4) @(negedge sysclk);
    chk_state("t1", 0, 1, 2, 1, cnt(1), cnt(0));
    chk("t1.starts", 32'(start_cnt - s0), 32'd1);

    // T2: square-wave update, 20 high / 20 low, two periods.
    s0 = start_cnt;
    repeat (2) begin
      bus.update = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge sysclk);
        bus.done = (i == 10);
      end
      bus.done   = 1'b0;
      bus.update = 1'b0;
      repeat (20) @(negedge sysclk);
    end
    chk_state("t2", 0, 1, 6, 3, cnt(3), cnt(0));
    chk("t2.starts", 32'(start_cnt - s0), 32'd2);

    // T3: ticks every 40 cycles while render takes ~100 cycles.
    s0 = start_cnt;
    for (int c = 0; c < 120; c++) begin
      bus.update = ((c % 40) == 0);
      bus.done   = (c == 100);
      @(negedge sysclk);
    end
    bus.update = 1'b0;
    bus.done   = 1'b0;
    chk_state("t3", 0, 0, 8, 4, cnt(4), cnt(2));
    chk("t3.starts", 32'(start_cnt - s0), 32'd1);

    // T4: done coincident with start is ignored; tick during SWAP relaunches.
    s0 = start_cnt;
    bus.update = 1'b1;
    @(negedge sysclk);
    bus.update = 1'b0;
    chk("t4.start", 32'(bus.start), 32'd1);
    bus.done = 1'b1;
    @(negedge sysclk);
    bus.done = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("t4.launch_done.busy", 32'(bus.busy), 32'd1);
    chk("t4.launch_done.buf_sel", 32'(bus.buf_sel), 32'd0);
    bus.done = 1'b1;
    @(negedge sysclk);
    bus.done   = 1'b0;
    bus.update = 1'b1;
    @(negedge sysclk);
    chk("t4.relaunch.start", 32'(bus.start), 32'd1);
    chk("t4.relaunch.yaw", 32'(bus.yaw), 32'd10);
    chk("t4.relaunch.pitch", 32'(bus.pitch), 32'd5);
    chk("t4.relaunch.buf_sel", 32'(bus.buf_sel), 32'd1);
    bus.update = 1'b0;
    @(negedge sysclk);
    chk("t4.start_one_cycle", 32'(bus.start), 32'd0);
    repeat (3) @(negedge sysclk);
    bus.done = 1'b1;
    @(negedge sysclk);
    bus.done = 1'b0;
    repeat (4) @(negedge sysclk);
    chk_state("t4", 0, 0, 12, 6, cnt(6), cnt(2));
    chk("t4.starts", 32'(start_cnt - s0), 32'd2);

    // T6: asynchronous reset mid-render, then a normal frame.
    bus.update = 1'b1;
    @(negedge sysclk);
    bus.update = 1'b0;
    repeat (2) @(negedge sysclk);
    chk("t6.busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6.rst.start", 32'(bus.start), 32'd0);
    chk_state("t6.rst", 0, 0, 0, 0, 0, 0);
    @(negedge sysclk);
    rst_n = 1'b1;
    @(negedge sysclk);
    bus.update = 1'b1;
    @(negedge sysclk);
    chk("t6.start", 32'(bus.start), 32'd1);
    chk("t6.yaw_at_start", 32'(bus.yaw), 32'd0);
    bus.update = 1'b0;
    repeat (3) @(negedge sysclk);
    bus.done = 1'b1;
    @(negedge sysclk);
    bus.done = 1'b0;
    repeat (4) @(negedge sysclk);
    chk_state("t6", 0, 1, 2, 1, cnt(1), cnt(0));

    // T5: 128 back-to-back frames from reset, then a spurious done in IDLE.
    rst_n = 1'b0;
    @(negedge sysclk);
    rst_n = 1'b1;
    @(negedge sysclk);
    s0 = start_cnt;
    repeat (128) begin
      bus.update = 1'b1;
      @(negedge sysclk);
      bus.update = 1'b0;
      @(negedge sysclk);
      bus.done = 1'b1;
      @(negedge sysclk);
      bus.done = 1'b0;
      @(negedge sysclk);
    end
    repeat (2) @(negedge sysclk);
    chk_state("t5", 0, 0, 0, 128, cnt(128), cnt(0));
    chk("t5.starts", 32'(start_cnt - s0), 32'd128);
    bus.done = 1'b1;
    @(negedge sysclk);
    bus.done = 1'b0;
    repeat (3) @(negedge sysclk);
    chk_state("t5.spurious", 0, 0, 0, 128, cnt(128), cnt(0));
    chk("t5.spurious.starts", 32'(start_cnt - s0), 32'd128);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

- Consumes the 60 Hz `update` tick from the frame clock and runs the per-frame control loop for the renderer.
- Per frame it launches a render with stable rotation angles, waits for completion, swaps framebuffers and advances the angles.
- Ticks that arrive while a frame is still rendering are dropped and counted.
- Sits between `frame_clk` and the rasteriser / framebuffer controller.

## Interface
Parameters:
- ANGLE_W, 8, width of yaw/pitch angle indices (trig LUT address width)
- YAW_STEP, 2, yaw increment per completed frame
- PITCH_STEP, 1, pitch increment per completed frame
- DROP_W, 16, width of dropped-frame counter

Ports:
- sysclk  in  1  system clock (125 MHz)
- rst_n  in  1  reset; asynchronous, active-low
- update  in  1  frame tick from frame_clk; one-cycle pulse in synthesis, square wave under TESTBENCH
- done  in  1  renderer finished current frame; one-cycle pulse
- start  out  1  one-cycle pulse launching a render
- busy  out  1  high whenever state is not IDLE
- yaw  out  ANGLE_W  yaw for current/next frame
- pitch  out  ANGLE_W  pitch for current/next frame
- buf_sel  out  1  framebuffer the renderer draws into; the display reads ~buf_sel
- frame_count  out  32  completed frames
- drop_count  out  DROP_W  dropped ticks, saturating

## Operation
- Tick detection: tick = update & ~update_q, where update_q is `update` registered.
  - Only rising edges count, so square-wave and pulse stimulus behave identically.
- FSM states: IDLE, LAUNCH, RENDER, SWAP.
  - IDLE: tick → LAUNCH.
  - LAUNCH: start=1 for exactly this cycle; → RENDER unconditionally.
  - RENDER: done → SWAP. A tick here increments drop_count (saturating at all-ones) and is discarded.
  - SWAP: toggle buf_sel; yaw += YAW_STEP and pitch += PITCH_STEP, both mod 2^ANGLE_W (natural wrap); frame_count += 1 (wraps). Then → LAUNCH if pending, else → IDLE; pending clears.
- Pending tick: a tick in SWAP sets `pending`, so it is not lost.
- Ticks in LAUNCH are dropped and counted.
- `done` outside RENDER is ignored, including `done` coincident with start.
- Simultaneous tick and done in RENDER: drop counted, then → SWAP.
- yaw/pitch change only on the SWAP edge. They are stable from start through done.
- Reset (any time, including mid-render): state IDLE, start=0, busy=0, yaw=0, pitch=0, buf_sel=0, frame_count=0, drop_count=0, pending=0, update_q=0.
  - The renderer must be reset by the same rst_n.

## Timing
- update first sampled high at edge E → start high in cycle E+1 (between edges E and E+1).
- Renderer may assert done no earlier than the cycle after start.
- done sampled at edge D → state SWAP in cycle D+1; buf_sel, yaw, pitch, frame_count take new values after edge D+1.
- Pending tick: start re-asserts in cycle D+2.
- Minimum tick-to-tick period for zero drops: render latency + 3 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- FRAME_STATS_EN defined: frame_count and drop_count counters are implemented as specified.
- FRAME_STATS_EN undefined: both counters are removed and the outputs are tied to 0; the rest of the FSM is unchanged.

## Structure
- render_pkg holds:
  - seq_state_t: enum IDLE/LAUNCH/RENDER/SWAP, 2-bit
  - angle_t: logic [ANGLE_W-1:0], with ANGLE_W default 8 as package constant
- Sub-module tick_detect (sysclk, rst_n, in, pulse) implements the rising-edge detector; reusable for other tick sources.

## Test plan
- Reset then single tick, done 10 cycles after start → one start pulse; buf_sel=1, yaw=2, pitch=1, frame_count=1, drop_count=0; busy low.
- Square-wave update (TESTBENCH style, high 20 cycles) → exactly one start per rising edge, none while update stays high.
- Tick during RENDER (done delayed 100 cycles, ticks every 40) → drop_count=2, only one start, frame_count=1.
- Tick coincident with SWAP → start re-asserts 2 cycles after done was sampled, with advanced yaw/pitch.
- 128 frames with ANGLE_W=8 → yaw wraps to 0, pitch=128; spurious done in IDLE changes nothing.
- rst_n low mid-RENDER → all outputs return to reset values immediately; next tick produces a normal frame with yaw=0.
